// File: rtl/inst_rom_loader_pkg.sv
// Shared widths, loader state encodings and the byte-lane merge helper for inst_rom_loader.
package inst_rom_loader_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned LANE_W  = 2;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] LD_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] LD_LOAD = 2'd1;
  localparam logic [STATE_W-1:0] LD_RUN  = 2'd2;

  // Return word with byte lane `lane` replaced by b (little-endian lanes).
  function automatic logic [INST_W-1:0] put_lane(input logic [INST_W-1:0] word,
                                                 input logic [BYTE_W-1:0] b,
                                                 input logic [LANE_W-1:0] lane);
    logic [INST_W-1:0] r;
    r = word;
    r[BYTE_W*lane +: BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Fetch port plus loader byte-stream signals of inst_rom_loader; master = core/loader, slave = ROM.
interface inst_rom_loader_if;
  import inst_rom_loader_pkg::*;

  logic              rom_ce_i;
  logic [ADDR_W-1:0] rom_addr_i;
  logic [INST_W-1:0] rom_data_o;
  logic              cpu_rst_o;
  logic              ld_start;
  logic              ld_valid;
  logic [BYTE_W-1:0] ld_byte;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_ovf;
  logic              fetch_err;

  modport master (
    output rom_ce_i, rom_addr_i, ld_start, ld_valid, ld_byte, ld_last,
    input  rom_data_o, cpu_rst_o, ld_ready, ld_done, ld_ovf, fetch_err
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start, ld_valid, ld_byte, ld_last,
    output rom_data_o, cpu_rst_o, ld_ready, ld_done, ld_ovf, fetch_err
  );

endinterface

// File: rtl/inst_rom_loader_packer.sv
// Packs accepted loader bytes into 32-bit words; word_valid_c/word_data_c present the word on the completing byte.
module inst_rom_loader_packer
  import inst_rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] data_byte,
  input  logic              last,
  output logic              word_valid_c,
  output logic [INST_W-1:0] word_data_c
);

  logic [LANE_W-1:0] lane;
  logic [INST_W-1:0] buffer;

  // Buffer upper lanes are always zero ahead of the fill point, so short final words come out zero-padded.
  assign word_data_c  = put_lane(buffer, data_byte, lane);
  assign word_valid_c = byte_en & ((lane == LANE_W'(LANES - 1)) | last);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane   <= '0;
      buffer <= '0;
    end else if (byte_en) begin
      if (word_valid_c) begin
        lane   <= '0;
        buffer <= '0;
      end else begin
        lane   <= lane + LANE_W'(1);
        buffer <= word_data_c;
      end
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with byte-stream program loader; holds the core in reset until a load completes.
// Optional INST_ROM_BOUNDS_EN: out-of-range fetches return NOP_INST and set sticky fetch_err.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter logic [INST_W-1:0] NOP_INST   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  inst_rom_loader_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] WPTR_TOP = '1;
  localparam logic [DEPTH_LOG2-1:0] WPTR_ONE = DEPTH_LOG2'(1);

  logic [STATE_W-1:0]    state, state_nxt;
  logic [DEPTH_LOG2-1:0] wptr, wptr_nxt;
  logic                  done_r, done_nxt;
  logic                  ovf_r, ovf_nxt;
  logic                  err_r, err_nxt;
  logic                  accept_c, start_acc_c, oob_c;
  logic                  word_valid_c;
  logic [INST_W-1:0]     word_data_c;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr_bits;
  logic [INST_W-1:0]     mem [DEPTH];

  assign accept_c    = bus.ld_valid & (state == LD_LOAD);
  assign start_acc_c = bus.ld_start & (state != LD_LOAD);
  assign idx         = bus.rom_addr_i[DEPTH_LOG2+1:2];

`ifdef INST_ROM_BOUNDS_EN
  assign oob_c            = |bus.rom_addr_i[ADDR_W-1:DEPTH_LOG2+2];
  assign unused_addr_bits = ^bus.rom_addr_i[1:0];
`else
  assign oob_c            = 1'b0;
  assign unused_addr_bits = ^{bus.rom_addr_i[ADDR_W-1:DEPTH_LOG2+2], bus.rom_addr_i[1:0]};
`endif

  inst_rom_loader_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_acc_c),
    .byte_en      (accept_c),
    .data_byte    (bus.ld_byte),
    .last         (bus.ld_last),
    .word_valid_c (word_valid_c),
    .word_data_c  (word_data_c)
  );

  // Next-state and flag logic.
  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    done_nxt  = 1'b0;
    ovf_nxt   = ovf_r;
    err_nxt   = err_r;
    case (state)
      LD_IDLE, LD_RUN: begin
        if (start_acc_c) begin
          state_nxt = LD_LOAD;
          wptr_nxt  = '0;
          ovf_nxt   = 1'b0;
        end
      end
      LD_LOAD: begin
        if (word_valid_c && (wptr != WPTR_TOP)) wptr_nxt = wptr + WPTR_ONE;
        if (accept_c && bus.ld_last) begin
          state_nxt = LD_RUN;
          done_nxt  = 1'b1;
        end else if (word_valid_c && (wptr == WPTR_TOP)) begin
          state_nxt = LD_RUN;
          done_nxt  = 1'b1;
          ovf_nxt   = 1'b1;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
    if ((state == LD_RUN) && bus.rom_ce_i && oob_c) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LD_IDLE;
      wptr   <= '0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      wptr   <= wptr_nxt;
      done_r <= done_nxt;
      ovf_r  <= ovf_nxt;
      err_r  <= err_nxt;
    end
  end

  // Memory is never cleared; a reset edge suppresses any in-flight word.
  always_ff @(posedge clk) begin
    if (word_valid_c && !rst) mem[wptr] <= word_data_c;
  end

  assign bus.rom_data_o = ((state == LD_RUN) && bus.rom_ce_i && !oob_c) ? mem[idx] : NOP_INST;
  assign bus.cpu_rst_o  = rst | (state != LD_RUN);
  assign bus.ld_ready   = (state == LD_LOAD);
  assign bus.ld_done    = done_r;
  assign bus.ld_ovf     = ovf_r;
  assign bus.fetch_err  = err_r;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: scoreboarded loads, fetch vector table, abort and overflow sequences.
module tb_inst_rom_loader;

`ifdef INST_ROM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fv_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];

  inst_rom_loader_if ifa ();
  inst_rom_loader_if ifb ();

  inst_rom_loader #(.DEPTH_LOG2(10), .NOP_INST(32'h0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  inst_rom_loader #(.DEPTH_LOG2(2),  .NOP_INST(32'h0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Load a program into dut_a, modelling the packed words into the scoreboard, then verify by fetch.
  task automatic load_a(input logic [7:0] bytes[$], input int unsigned maxgap, input bit hold_start);
    logic [31:0] w;
    logic [31:0] last_word;
    int          lane;
    int unsigned wi;
    int unsigned last_idx;
    int unsigned g;
    sb_t         e;
    w = '0; lane = 0; wi = 0; last_idx = 0; last_word = '0;
    step();
    ifa.ld_start = 1'b1;
    step();
    ifa.ld_start = hold_start;
    check1("load_entry_ready", ifa.ld_ready, 1'b1);
    check1("load_entry_cpu_rst", ifa.cpu_rst_o, 1'b1);
    foreach (bytes[i]) begin
      bit last;
      last = (i == bytes.size() - 1);
      ifa.ld_valid = 1'b1;
      ifa.ld_byte  = bytes[i];
      ifa.ld_last  = last;
      if (last) ifa.ld_start = 1'b0;
      w[8*lane +: 8] = bytes[i];
      if (lane == 3 || last) begin
        e.idx = wi; e.data = w;
        sb_q.push_back(e);
        last_idx = wi; last_word = w;
        wi++; w = '0; lane = 0;
      end else begin
        lane++;
      end
      step();
      ifa.ld_valid = 1'b0;
      ifa.ld_last  = 1'b0;
      if (!last && maxgap > 0) begin
        g = $urandom_range(maxgap, 1);
        repeat (g) begin
          ifa.ld_last = 1'($urandom_range(1, 0));
          step();
        end
        ifa.ld_last = 1'b0;
      end
    end
    check1("done_pulse", ifa.ld_done, 1'b1);
    check1("ready_drop", ifa.ld_ready, 1'b0);
    check1("cpu_rst_fall", ifa.cpu_rst_o, 1'b0);
    check1("no_ovf", ifa.ld_ovf, 1'b0);
    ifa.rom_ce_i   = 1'b1;
    ifa.rom_addr_i = 32'(last_idx * 4);
    #1;
    check("first_fetch", ifa.rom_data_o, last_word);
    step();
    check1("done_one_cycle", ifa.ld_done, 1'b0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      ifa.rom_addr_i = 32'(e.idx * 4) | 32'($urandom_range(3, 0));
      #1;
      check("sb_fetch", ifa.rom_data_o, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    fv_t        tbl[6];

    rst = 1'b1;
    ifa.rom_ce_i = 1'b1; ifa.rom_addr_i = '0; ifa.ld_start = 1'b0; ifa.ld_valid = 1'b0;
    ifa.ld_byte = '0; ifa.ld_last = 1'b0;
    ifb.rom_ce_i = 1'b1; ifb.rom_addr_i = '0; ifb.ld_start = 1'b0; ifb.ld_valid = 1'b0;
    ifb.ld_byte = '0; ifb.ld_last = 1'b0;
    repeat (3) step();
    check("rst_data", ifa.rom_data_o, 32'h0);
    check1("rst_cpu_rst", ifa.cpu_rst_o, 1'b1);
    check1("rst_ready", ifa.ld_ready, 1'b0);
    check1("rst_done", ifa.ld_done, 1'b0);
    check1("rst_ovf", ifa.ld_ovf, 1'b0);
    check1("rst_fetch_err", ifa.fetch_err, 1'b0);
    check1("rst_ready_b", ifb.ld_ready, 1'b0);
    rst = 1'b0;
    step();
    check1("idle_cpu_rst", ifa.cpu_rst_o, 1'b1);
    check("idle_data", ifa.rom_data_o, 32'h0);

    q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_a(q, 0, 1'b0);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    load_a(q, 0, 1'b0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    load_a(q, 5, 1'b1);

    // Image now: mem0=44332211 mem1=88776655 mem2=00000099.
    tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[1] = '{1'b1, 32'h0000_0001, 32'h4433_2211};
    tbl[2] = '{1'b1, 32'h0000_0006, 32'h8877_6655};
    tbl[3] = '{1'b1, 32'h0000_000B, 32'h0000_0099};
    tbl[4] = '{1'b0, 32'h0000_0008, 32'h0000_0000};
    tbl[5] = '{1'b1, 32'h0000_1000, BOUNDS ? 32'h0 : 32'h4433_2211};
    for (int i = 0; i < 6; i++) begin
      ifa.rom_ce_i   = tbl[i].ce;
      ifa.rom_addr_i = tbl[i].addr;
      #1;
      check($sformatf("fetch_vec%0d", i), ifa.rom_data_o, tbl[i].exp);
      step();
    end
    check1("fetch_err_set", ifa.fetch_err, BOUNDS);
    ifa.rom_addr_i = 32'h0;
    step();
    check1("fetch_err_sticky", ifa.fetch_err, BOUNDS);
    check("fetch_after_err", ifa.rom_data_o, 32'h4433_2211);

    // Abort a load with reset after six bytes.
    ifa.ld_start = 1'b1;
    step();
    ifa.ld_start = 1'b0;
    q = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h01, 8'h02};
    foreach (q[i]) begin
      ifa.ld_valid = 1'b1;
      ifa.ld_byte  = q[i];
      step();
    end
    ifa.ld_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifa.rom_ce_i = 1'b1; ifa.rom_addr_i = 32'h0;
    #1;
    check1("abort_cpu_rst", ifa.cpu_rst_o, 1'b1);
    check1("abort_ready", ifa.ld_ready, 1'b0);
    check("abort_data", ifa.rom_data_o, 32'h0);
    check1("abort_fetch_err_clr", ifa.fetch_err, 1'b0);
    q = '{8'h5A};
    load_a(q, 0, 1'b0);
    ifa.rom_addr_i = 32'h4;
    #1;
    check("abort_partial_dropped", ifa.rom_data_o, 32'h8877_6655);

    // Overflow on the 4-word instance.
    step();
    ifb.ld_start = 1'b1;
    step();
    ifb.ld_start = 1'b0;
    check1("b_entry_ready", ifb.ld_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ifb.ld_valid = 1'b1;
      ifb.ld_byte  = 8'(i);
      step();
      check1($sformatf("b_done%0d", i), ifb.ld_done, i == 15);
      check1($sformatf("b_ready%0d", i), ifb.ld_ready, i < 15);
      check1($sformatf("b_ovf%0d", i), ifb.ld_ovf, i >= 15);
      check1($sformatf("b_cpu_rst%0d", i), ifb.cpu_rst_o, i < 15);
    end
    ifb.ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp;
      exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      ifb.rom_ce_i   = 1'b1;
      ifb.rom_addr_i = 32'(k * 4);
      #1;
      check($sformatf("b_word%0d", k), ifb.rom_data_o, exp);
    end
    ifb.rom_addr_i = 32'h10;
    #1;
    check("b_alias", ifb.rom_data_o, BOUNDS ? 32'h0 : 32'h0302_0100);
    step();
    check1("b_fetch_err", ifb.fetch_err, BOUNDS);
    ifb.rom_addr_i = 32'h0;
    ifb.ld_start = 1'b1;
    step();
    ifb.ld_start = 1'b0;
    check1("b_ovf_clr", ifb.ld_ovf, 1'b0);
    check1("b_reload_ready", ifb.ld_ready, 1'b1);
    check1("b_reload_cpu_rst", ifb.cpu_rst_o, 1'b1);
    ifb.ld_valid = 1'b1; ifb.ld_byte = 8'hEE; ifb.ld_last = 1'b1;
    step();
    ifb.ld_valid = 1'b0; ifb.ld_last = 1'b0;
    check1("b_reload_done", ifb.ld_done, 1'b1);
    check1("b_reload_ovf", ifb.ld_ovf, 1'b0);
    check("b_reload_word", ifb.rom_data_o, 32'h0000_00EE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
